// File: rtl/traffic_light_ctrl_multi_if.sv
// Lamp-side interface of the multi-direction traffic-light controller:
// run/demand inputs in, per-direction lamps and phase status out.
interface traffic_light_ctrl_multi_if #(
  parameter int NUM_DIR = 4,
  parameter int DIR_W   = $clog2(NUM_DIR)
);
  logic                   enable;
  logic [NUM_DIR-1:0]     dir_req;
  logic [3*NUM_DIR-1:0]   light;
  logic [DIR_W-1:0]       active_dir;
  logic [1:0]             phase;
  logic                   grant_pulse;

  modport master (
    output enable, dir_req,
    input  light, active_dir, phase, grant_pulse
  );

  modport slave (
    input  enable, dir_req,
    output light, active_dir, phase, grant_pulse
  );
endinterface

// File: rtl/traffic_light_ctrl_multi.sv
// N-direction traffic-light controller: round-robin green among demanding
// directions, with yellow and all-red clearance between grants.
module traffic_light_ctrl_multi #(
  parameter int NUM_DIR    = 4,
  parameter int GREEN_CYC  = 8,
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 2,
  parameter int CNT_W      = 16,
  parameter int DIR_W      = $clog2(NUM_DIR)
) (
  input  logic                        clk,
  input  logic                        reset,
  traffic_light_ctrl_multi_if.slave   bus
);

  typedef enum logic [1:0] {
    PH_ALLRED = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2
  } phase_e;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  phase_e               state;
  logic [CNT_W-1:0]     cnt;
  logic [DIR_W-1:0]     active_dir;
  logic [DIR_W-1:0]     next_dir;
  logic [3*NUM_DIR-1:0] light;
  logic                 grant_pulse;

  logic                 req_found;
  logic [DIR_W-1:0]     req_dir;

  // Lamp pattern for a phase: only the owning direction may leave red.
  function automatic logic [3*NUM_DIR-1:0] lamps(input phase_e ph,
                                                 input logic [DIR_W-1:0] dir);
    logic [3*NUM_DIR-1:0] v;
    for (int d = 0; d < NUM_DIR; d++) begin
      v[3*d +: 3] = LAMP_RED;
      if (DIR_W'(d) == dir) begin
        if (ph == PH_GREEN)       v[3*d +: 3] = LAMP_GRN;
        else if (ph == PH_YELLOW) v[3*d +: 3] = LAMP_YEL;
      end
    end
    return v;
  endfunction

  // Round-robin search starting just after the current owner; the owner's
  // own request never counts, so a lone requester keeps its green.
  always_comb begin
    logic [DIR_W-1:0] idx;
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    req_found = 1'b0;
    req_dir   = active_dir;
    idx       = '0;
    for (int k = 1; k < NUM_DIR; k++) begin
      idx = DIR_W'((int'(active_dir) + k) % NUM_DIR);
      if (!req_found && bus.dir_req[idx]) begin
        req_found = 1'b1;
        req_dir   = idx;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= PH_ALLRED;
      cnt         <= CNT_W'(ALLRED_CYC - 1);
      active_dir  <= '0;
      next_dir    <= '0;
      light       <= lamps(PH_ALLRED, '0);
      grant_pulse <= 1'b0;
    end else if (!bus.enable) begin
      grant_pulse <= 1'b0;
    end else begin
      grant_pulse <= 1'b0;
      unique case (state)
        PH_ALLRED: begin
          if (cnt == '0) begin
            state       <= PH_GREEN;
            active_dir  <= next_dir;
            cnt         <= CNT_W'(GREEN_CYC - 1);
            grant_pulse <= 1'b1;
            light       <= lamps(PH_GREEN, next_dir);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PH_GREEN: begin
          // With no competing demand the counter parks at zero and the
          // search repeats every cycle (green extension).
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (req_found) begin
            next_dir <= req_dir;
            state    <= PH_YELLOW;
            cnt      <= CNT_W'(YELLOW_CYC - 1);
            light    <= lamps(PH_YELLOW, active_dir);
          end
        end
        PH_YELLOW: begin
          if (cnt == '0) begin
            state <= PH_ALLRED;
            cnt   <= CNT_W'(ALLRED_CYC - 1);
            light <= lamps(PH_ALLRED, active_dir);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= PH_ALLRED;
          cnt   <= CNT_W'(ALLRED_CYC - 1);
          light <= lamps(PH_ALLRED, active_dir);
        end
      endcase
    end
  end

  assign bus.light       = light;
  assign bus.active_dir  = active_dir;
  assign bus.phase       = state;
  assign bus.grant_pulse = grant_pulse;

endmodule

// File: tb/tb_traffic_light_ctrl_multi.sv
// Self-checking bench for traffic_light_ctrl_multi: reset vector table,
// directed corner sequences, and randomized traffic against a timing model.
module tb_traffic_light_ctrl_multi;

  localparam int N = 4;
  localparam int G = 8;
  localparam int Y = 3;
  localparam int R = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  traffic_light_ctrl_multi_if #(.NUM_DIR(N)) bus ();

  traffic_light_ctrl_multi #(
    .NUM_DIR   (N),
    .GREEN_CYC (G),
    .YELLOW_CYC(Y),
    .ALLRED_CYC(R),
    .CNT_W     (16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase tracked as elapsed cycles in that phase; a phase
  // of length DUR ends once DUR cycles have elapsed (green may overstay).
  int m_ph;      // 0 allred, 1 green, 2 yellow
  int m_age;
  int m_act;
  int m_next;
  bit m_grant;

  function automatic logic [3*N-1:0] model_light();
    logic [3*N-1:0] v;
    for (int d = 0; d < N; d++) begin
      if (d == m_act && m_ph == 1)      v[3*d +: 3] = 3'b001;
      else if (d == m_act && m_ph == 2) v[3*d +: 3] = 3'b010;
      else                              v[3*d +: 3] = 3'b100;
    end
    return v;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_age = 0; m_act = 0; m_next = 0; m_grant = 1'b0;
  endtask

  task automatic model_step();
    int pick;
    if (reset) begin
      model_reset();
    end else if (!bus.enable) begin
      m_grant = 1'b0;
    end else begin
      m_grant = 1'b0;
      case (m_ph)
        0: if (m_age >= R - 1) begin
             m_ph = 1; m_act = m_next; m_age = 0; m_grant = 1'b1;
           end else m_age++;
        1: if (m_age >= G - 1) begin
             pick = -1;
             for (int k = 1; k < N; k++)
               if (pick < 0 && bus.dir_req[(m_act + k) % N]) pick = (m_act + k) % N;
             if (pick >= 0) begin
               m_next = pick; m_ph = 2; m_age = 0;
             end
           end else m_age++;
        default: if (m_age >= Y - 1) begin
             m_ph = 0; m_age = 0;
           end else m_age++;
      endcase
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " light"},  32'(bus.light),       32'(model_light()));
    check({tag, " phase"},  32'(bus.phase),       32'(m_ph));
    check({tag, " active"}, 32'(bus.active_dir),  32'(m_act));
    check({tag, " grant"},  32'(bus.grant_pulse), 32'(m_grant));
  endtask

  // One clock edge: model follows the edge, outputs compared on the falling edge.
  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) tick("rst");
    reset = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0]   req;
    logic           en;
    logic [3*N-1:0] light;
    logic [1:0]     phase;
    logic [1:0]     act;
    logic           grant;
  } vec_t;

  vec_t tbl[16];
  bit   saw12;

  task automatic set_vec(input int i, input logic [11:0] l, input logic [1:0] ph,
                         input logic [1:0] a, input logic g);
    tbl[i].req = 4'hF; tbl[i].en = 1'b1;
    tbl[i].light = l; tbl[i].phase = ph; tbl[i].act = a; tbl[i].grant = g;
  endtask

  initial begin
    // Post-reset timeline with every direction requesting.
    set_vec(0,  12'h924, 2'd0, 2'd0, 1'b0);
    set_vec(1,  12'h924, 2'd0, 2'd0, 1'b0);
    set_vec(2,  12'h921, 2'd1, 2'd0, 1'b1);
    for (int i = 3; i <= 9; i++) set_vec(i, 12'h921, 2'd1, 2'd0, 1'b0);
    for (int i = 10; i <= 12; i++) set_vec(i, 12'h922, 2'd2, 2'd0, 1'b0);
    set_vec(13, 12'h924, 2'd0, 2'd0, 1'b0);
    set_vec(14, 12'h924, 2'd0, 2'd0, 1'b0);
    set_vec(15, 12'h90C, 2'd1, 2'd1, 1'b1);

    model_reset();
    reset       = 1'b1;
    bus.enable  = 1'b1;
    bus.dir_req = 4'hF;
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 16; i++) begin
      if (i > 0) begin
        bus.dir_req = tbl[i].req;
        bus.enable  = tbl[i].en;
        tick("vec");
      end
      check($sformatf("vec%0d light", i),  32'(bus.light),       32'(tbl[i].light));
      check($sformatf("vec%0d phase", i),  32'(bus.phase),       32'(tbl[i].phase));
      check($sformatf("vec%0d active", i), 32'(bus.active_dir),  32'(tbl[i].act));
      check($sformatf("vec%0d grant", i),  32'(bus.grant_pulse), 32'(tbl[i].grant));
    end

    // Skip idle directions: only dir3 requests.
    bus.dir_req = 4'b1000;
    do_reset();
    saw12 = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick("skip");
      if (bus.light[5:3] != 3'b100 || bus.light[8:6] != 3'b100) saw12 = 1'b1;
    end
    check("skip active", 32'(bus.active_dir), 32'd3);
    check("skip phase",  32'(bus.phase),      32'd1);
    check("skip dirs1-2 red", 32'(saw12),     32'd0);

    // Wrap: from dir3, only dir0 requests.
    bus.dir_req = 4'b0001;
    repeat (13) tick("wrap");
    check("wrap active", 32'(bus.active_dir), 32'd0);
    check("wrap light",  32'(bus.light),      32'h921);
    check("wrap grant",  32'(bus.grant_pulse), 32'd1);

    // Extension: no demand keeps dir0 green; late request triggers yellow.
    bus.dir_req = 4'b0000;
    do_reset();
    repeat (60) tick("ext");
    check("ext c60 phase", 32'(bus.phase), 32'd1);
    check("ext c60 light", 32'(bus.light), 32'h921);
    bus.dir_req = 4'b0100;
    tick("ext");
    check("ext c61 light", 32'(bus.light), 32'h922);
    repeat (5) tick("ext");
    check("ext c66 light",  32'(bus.light),      32'h864);
    check("ext c66 active", 32'(bus.active_dir), 32'd2);

    // Reset in the second yellow cycle of dir1.
    bus.dir_req = 4'hF;
    do_reset();
    repeat (24) tick("midrst");
    check("midrst pre phase",  32'(bus.phase),      32'd2);
    check("midrst pre active", 32'(bus.active_dir), 32'd1);
    reset = 1'b1;
    tick("midrst");
    reset = 1'b0;
    check("midrst light",  32'(bus.light),      32'h924);
    check("midrst phase",  32'(bus.phase),      32'd0);
    check("midrst active", 32'(bus.active_dir), 32'd0);

    // Freeze on the 4th green cycle for 10 cycles.
    do_reset();
    repeat (5) tick("frz");
    check("frz c5 light", 32'(bus.light), 32'h921);
    bus.enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick("frz");
      check("frz hold light", 32'(bus.light), 32'h921);
    end
    bus.enable = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick("frz");
      check($sformatf("frz resume%0d phase", i), 32'(bus.phase), 32'd1);
    end
    tick("frz");
    check("frz yellow", 32'(bus.phase), 32'd2);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      reset       = ($urandom_range(0, 199) == 0);
      bus.enable  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) bus.dir_req = 4'($urandom);
      tick("rand");
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
